// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory
// word address and loads the IF/ID pipeline register for decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [9:0]  imem_addr,
    input  logic [31:0] imem_dout,
    output logic [31:0] pc,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {
        START = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;

    localparam if_id_t BUBBLE = '{
        instr: NOP_INSTR,
        pc4:   32'h0,
        valid: 1'b0
    };

    state_t      state, state_n;
    logic [31:0] pc_q, pc_n;
    if_id_t      ifid_q, ifid_n;
    logic        fault_q, fault_n;

    logic [31:0] pc_inc;
    logic        pc_bad;

    assign pc_inc = pc_q + 32'd4;
    assign pc_bad = (pc_q[1:0] != 2'b00) || (pc_q[31:12] != 20'h0);

    // State register: PC, IF/ID, fault flag and FSM state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= START;
            pc_q    <= RESET_PC;
            ifid_q  <= BUBBLE;
            fault_q <= 1'b0;
        end else begin
            state   <= state_n;
            pc_q    <= pc_n;
            ifid_q  <= ifid_n;
            fault_q <= fault_n;
        end
    end

    // Next-state logic: redirect beats stall beats fault beats flush.
    always_comb begin
        state_n = state;
        pc_n    = pc_q;
        ifid_n  = ifid_q;
        fault_n = fault_q;
        case (state)
            START: begin
                state_n = RUN;
                ifid_n  = BUBBLE;
            end
            RUN: begin
                if (redirect_valid) begin
                    pc_n   = redirect_pc;
                    ifid_n = BUBBLE;
                end else if (stall) begin
                    pc_n   = pc_q;
                end else if (pc_bad) begin
                    fault_n = 1'b1;
                    ifid_n  = BUBBLE;
                    state_n = HALT;
                end else if (flush) begin
                    ifid_n = BUBBLE;
                    pc_n   = pc_inc;
                end else begin
                    ifid_n.instr = imem_dout;
                    ifid_n.pc4   = pc_inc;
                    ifid_n.valid = 1'b1;
                    pc_n         = pc_inc;
                end
            end
            HALT: begin
                ifid_n = BUBBLE;
                if (redirect_valid) begin
                    pc_n    = redirect_pc;
                    fault_n = 1'b0;
                    state_n = RUN;
                end
            end
            default: begin
                state_n = START;
                pc_n    = RESET_PC;
                ifid_n  = BUBBLE;
                fault_n = 1'b0;
            end
        endcase
    end

    assign pc          = pc_q;
    assign imem_addr   = pc_q[11:2];
    assign ifid_instr  = ifid_q.instr;
    assign ifid_pc4    = ifid_q.pc4;
    assign ifid_valid  = ifid_q.valid;
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized self-checking bench for fetch_stage against a behavioural
// model of the fetch rules, plus directed boundary scenarios.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [9:0]  imem_addr;
    logic [31:0] imem_dout;
    logic [31:0] pc;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        fetch_fault;

    int checks = 0;
    int failures = 0;

    logic [31:0] rom [1024];

    fetch_stage dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .flush(flush),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .imem_addr(imem_addr),
        .imem_dout(imem_dout),
        .pc(pc),
        .ifid_instr(ifid_instr),
        .ifid_pc4(ifid_pc4),
        .ifid_valid(ifid_valid),
        .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    assign imem_dout = rom[imem_addr];

    // reference model
    bit          m_first;
    bit          m_halted;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    bit          m_valid;
    bit          m_fault;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_bubble();
        m_instr = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 0;
    endtask

    task automatic model_reset();
        m_first  = 1;
        m_halted = 0;
        m_pc     = 32'h0;
        m_fault  = 0;
        m_bubble();
    endtask

    task automatic model_edge();
        if (m_first) begin
            m_first = 0;
        end else if (m_halted) begin
            m_bubble();
            if (redirect_valid) begin
                m_pc     = redirect_pc;
                m_fault  = 0;
                m_halted = 0;
            end
        end else if (redirect_valid) begin
            m_pc = redirect_pc;
            m_bubble();
        end else if (stall) begin
        end else if ((m_pc % 4) != 0 || m_pc >= 32'h1000) begin
            m_fault  = 1;
            m_halted = 1;
            m_bubble();
        end else if (flush) begin
            m_bubble();
            m_pc = m_pc + 4;
        end else begin
            m_instr = rom[m_pc / 4];
            m_pc4   = m_pc + 4;
            m_valid = 1;
            m_pc    = m_pc + 4;
        end
    endtask

    task automatic compare_all();
        logic [31:0] wa;
        wa = m_pc / 4;
        chk("pc", pc, m_pc);
        chk("imem_addr", {22'h0, imem_addr}, {22'h0, wa[9:0]});
        chk("ifid_instr", ifid_instr, m_instr);
        chk("ifid_pc4", ifid_pc4, m_pc4);
        chk("ifid_valid", {31'h0, ifid_valid}, {31'h0, m_valid});
        chk("fetch_fault", {31'h0, fetch_fault}, {31'h0, m_fault});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic drive(input bit r, input logic [31:0] t,
                         input bit s, input bit f);
        redirect_valid = r;
        redirect_pc    = t;
        stall          = s;
        flush          = f;
    endtask

    task automatic async_reset();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        reset = 1'b0;
        compare_all();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = $urandom;
        rom[0] = 32'h20080001;
        rom[1] = 32'h20090002;
        rom[2] = 32'h01095020;
        reset = 1'b1;
        drive(0, 32'h0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        compare_all();
        reset = 1'b0;

        // sequential fetch
        step();
        chk("start_valid", {31'h0, ifid_valid}, 32'h0);
        step();
        chk("seq0_instr", ifid_instr, 32'h20080001);
        chk("seq0_pc4", ifid_pc4, 32'h4);
        step();
        chk("seq1_instr", ifid_instr, 32'h20090002);
        chk("seq1_pc4", ifid_pc4, 32'h8);
        step();
        chk("seq2_instr", ifid_instr, 32'h01095020);
        chk("seq2_pc4", ifid_pc4, 32'hc);

        // upper-ROM redirect
        drive(1, 32'h800, 0, 0);
        step();
        drive(0, 32'h0, 0, 0);
        chk("up_addr", {22'h0, imem_addr}, 32'd512);
        chk("up_bubble", {31'h0, ifid_valid}, 32'h0);
        step();
        chk("up_instr", ifid_instr, rom[512]);
        chk("up_pc4", ifid_pc4, 32'h804);

        // stall hold at pc = 8
        drive(1, 32'h8, 0, 0);
        step();
        drive(0, 32'h0, 1, 0);
        repeat (3) begin
            step();
            chk("stall_pc", pc, 32'h8);
        end
        drive(0, 32'h0, 0, 0);
        step();
        chk("resume_pc4", ifid_pc4, 32'hc);
        drive(0, 32'h0, 1, 1);
        step();
        drive(0, 32'h0, 0, 0);
        step();
        chk("stflush_valid", {31'h0, ifid_valid}, 32'h1);
        chk("stflush_pc4", ifid_pc4, 32'h10);

        // priority
        drive(1, 32'h40, 1, 1);
        step();
        drive(0, 32'h0, 0, 0);
        chk("prio_pc", pc, 32'h40);
        chk("prio_valid", {31'h0, ifid_valid}, 32'h0);

        // fault and recovery
        drive(1, 32'h6, 0, 0);
        step();
        drive(0, 32'h0, 0, 0);
        step();
        chk("fault_set", {31'h0, fetch_fault}, 32'h1);
        repeat (5) begin
            step();
            chk("halt_pc", pc, 32'h6);
            chk("halt_valid", {31'h0, ifid_valid}, 32'h0);
        end
        drive(1, 32'h10, 0, 0);
        step();
        drive(0, 32'h0, 0, 0);
        chk("fault_clr", {31'h0, fetch_fault}, 32'h0);
        step();
        chk("rec_instr", ifid_instr, rom[4]);
        chk("rec_pc4", ifid_pc4, 32'h14);

        // top-of-space boundary: 0xFFC fetches, 0x1000 faults
        drive(1, 32'hffc, 0, 0);
        step();
        drive(0, 32'h0, 0, 0);
        step();
        chk("top_instr", ifid_instr, rom[1023]);
        chk("top_pc", pc, 32'h1000);
        step();
        chk("oob_fault", {31'h0, fetch_fault}, 32'h1);
        drive(1, 32'h20, 0, 0);
        step();
        drive(0, 32'h0, 0, 0);
        step();
        chk("pre_rst_pc", pc, 32'h24);

        // async reset mid-run
        async_reset();
        chk("rst_pc", pc, 32'h0);
        step();
        step();
        chk("rst_refetch", ifid_instr, 32'h20080001);

        // randomized phase
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] tgt;
            case ($urandom_range(0, 3))
                0, 1: tgt = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
                2: tgt = {20'h0, 12'($urandom)} | 32'h1;
                default: tgt = ($urandom % 2) ? 32'hffc : $urandom;
            endcase
            drive($urandom_range(0, 99) < 6, tgt,
                  $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10);
            if ($urandom_range(0, 299) == 0) async_reset();
            else step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage that drives the word address of the dual-ROM instruction memory and consumes its 32-bit read data. It owns the program counter, issues sequential fetches, and applies redirects (branch/jump) and stalls. It registers each fetched instruction and its PC+4 into the IF/ID pipeline register for the decode stage. It detects misaligned or out-of-range PCs and halts fetch until redirected.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned and below 32'h0000_1000
- NOP_INSTR, 32'h0000_0000, instruction word placed in IF/ID on a bubble

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- stall  input  1  hold PC and IF/ID (load-use hazard from decode)
- flush  input  1  replace the next IF/ID contents with a bubble
- redirect_valid  input  1  load redirect_pc into PC this cycle
- redirect_pc  input  32  byte address of redirect target
- imem_addr  output  10  word address to instruction memory, equal to pc[11:2]
- imem_dout  input  32  instruction word; combinational read of imem_addr within the same cycle
- pc  output  32  current fetch PC (byte address)
- ifid_instr  output  32  registered instruction
- ifid_pc4  output  32  registered PC+4 of that instruction
- ifid_valid  output  1  IF/ID holds a real instruction
- fetch_fault  output  1  sticky; PC misaligned or outside the 4 KiB instruction space

## Operation
- States: START, RUN, HALT.
- START: entered on reset. The PC holds RESET_PC and IF/ID is a bubble. Next edge moves to RUN unconditionally.
- RUN, per rising edge, priority highest first:
  - redirect_valid: pc <= redirect_pc; IF/ID <= bubble (stall ignored).
  - stall: pc, IF/ID, and state held; flush ignored while stalled.
  - Fault (pc[1:0] != 0 or pc[31:12] != 0): fetch_fault <= 1; IF/ID <= bubble; state -> HALT; pc held.
  - flush: IF/ID <= bubble; pc <= pc + 4.
  - Otherwise: ifid_instr <= imem_dout; ifid_pc4 <= pc + 4; ifid_valid <= 1; pc <= pc + 4.
- HALT: pc held; IF/ID is a bubble every cycle; stall and flush are ignored.
  - redirect_valid: pc <= redirect_pc; fetch_fault <= 0; state -> RUN. A bad target re-faults on the following cycle.
- Bubble: ifid_instr = NOP_INSTR, ifid_pc4 = 0, ifid_valid = 0.
- PC arithmetic is modulo 2^32. Incrementing from 32'h0000_0FFC gives 32'h0000_1000, which faults on the next RUN cycle; it does not wrap to 0.
- imem_addr is always pc[11:2], including in HALT and START. Its read data is only captured under the RUN "otherwise" rule.

## Timing
- Reset values: pc = RESET_PC, imem_addr = RESET_PC[11:2], ifid_instr = NOP_INSTR, ifid_pc4 = 0, ifid_valid = 0, fetch_fault = 0, state = START.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.
- Latency:
  - The instruction at pc in cycle N appears on ifid_* after the edge ending cycle N.
  - The first valid IF/ID appears 2 edges after reset deassertion: the START edge, then the fetch of RESET_PC.
- Redirect: the target is fetched in the cycle after the redirect edge. Redirect-to-valid-IF/ID latency is 2 edges, with exactly one bubble between.
- Stall: every output holds its value for as long as stall is high. Fetch resumes on the first edge with stall low.
- Simultaneous events:
  - redirect + stall: redirect wins.
  - redirect + flush: the redirect rule applies.
  - stall + flush: the stall rule applies; flush is dropped, and decode must reassert it.
- fetch_fault rises on the edge that detects the fault and stays high until a HALT redirect or reset.

## Test plan
- Sequential fetch: ROM1 words 0..2 = 0x20080001, 0x20090002, 0x01095020; release reset -> ifid_valid first high 2 edges later with ifid_instr 0x20080001, ifid_pc4 4, then 0x20090002/8, then 0x01095020/12.
- Upper-ROM redirect: redirect_valid for 1 cycle, redirect_pc = 0x800 -> imem_addr = 512 next cycle, one bubble, then ifid_instr = ROM2 word 0, ifid_pc4 = 0x804.
- Stall hold: stall high 3 cycles with pc = 8 -> pc, ifid_instr, ifid_pc4, ifid_valid unchanged for 3 edges; resume with ifid_pc4 = 12; stall + flush together -> no bubble.
- Priority: redirect_valid, stall, and flush all high, redirect_pc = 0x40 -> pc = 0x40, ifid_valid = 0.
- Fault and recovery: redirect_pc = 0x6 -> next edge fetch_fault = 1, state HALT, pc held at 0x6, ifid_valid stays 0 for 5 cycles; redirect_pc = 0x10 -> fetch_fault = 0, valid fetch of word 4 two edges later.
- Async reset mid-run: assert reset between edges at pc = 0x24 -> pc = 0, ifid_valid = 0, fetch_fault = 0 without waiting for a clock edge; fetch restarts via START.
